wb_arbiter: RTL and testbench

Writeback arbiter that drives the single write port of the 32x64 register file (REG_WRITE/WR_REG/WR_DATA).
- Merges two writeback sources: the single-cycle ALU path and the multi-cycle load path.
- Load path passes through a small FIFO.
- Sits between execute/memory and the register file.
- Exports a pending-load mask for the hazard unit.

---
 rtl/wb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU result and FIFO-buffered loads onto the single register-file write port.
// Latency: ALU grant -> REG_WRITE next cycle; load handshake -> REG_WRITE two cycles later at the earliest.
// Backpressure: LD_READY drops when the load FIFO is full; ALU_READY drops for one cycle when a waiting load has been starved.

// Generic FIFO that also exposes every slot and its valid bit, so callers can scan the queued contents.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: o_full blocks push and o_empty blocks pop; push and pop in the same cycle are allowed when not full.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [W-1:0]       i_push_dat,
    input  logic               i_pop,
    output logic               o_full,
    output logic               o_empty,
    output logic [W-1:0]       o_head_dat,
    output logic [DEPTH*W-1:0] o_ent_dat,
    output logic [DEPTH-1:0]   o_ent_vld
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_full     = &r_vld;
    assign o_empty    = ~|r_vld;
    assign w_push     = i_push & ~o_full;
    assign w_pop      = i_pop & ~o_empty;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_ent_vld  = r_vld;

    always_comb begin
        o_ent_dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_dat[i*W +: W] = r_mem[i];
        end
    end

    // Per-slot valid bits instead of a count: a push and a pop can only coincide on distinct slots.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end
endmodule

module wb_arbiter #(
    parameter int DATA_W       = 64,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ALU_VALID,
    output logic              ALU_READY,
    input  logic [4:0]        ALU_RD,
    input  logic [DATA_W-1:0] ALU_DATA,
    input  logic              LD_VALID,
    output logic              LD_READY,
    input  logic [4:0]        LD_RD,
    input  logic [DATA_W-1:0] LD_DATA,
    output logic              REG_WRITE,
    output logic [4:0]        WR_REG,
    output logic [DATA_W-1:0] WR_DATA,
    output logic [31:0]       PENDING
);
    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] dat;
    } ld_ent_t;

    localparam int ENT_W = $bits(ld_ent_t);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    ld_ent_t                     w_head;
    logic [FIFO_DEPTH*ENT_W-1:0] w_ent_flat;
    logic [FIFO_DEPTH-1:0]       w_ent_vld;
    logic                        w_ld_push;
    logic                        w_starved;
    logic                        w_alu_gnt;
    logic                        w_ld_gnt;
    logic [4:0]                  w_gnt_rd;
    logic [DATA_W-1:0]           w_gnt_dat;
    logic                        w_wr_en;
    logic [31:0]                 w_pending;

    logic [SW-1:0]               r_starve;
    logic                        r_reg_write;
    logic [4:0]                  r_wr_reg;
    logic [DATA_W-1:0]           r_wr_data;

    assign LD_READY  = ~RST & ~w_fifo_full;
    assign w_ld_push = LD_VALID & LD_READY;

    wb_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ld_fifo (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_push     (w_ld_push),
        .i_push_dat ({LD_RD, LD_DATA}),
        .i_pop      (w_ld_gnt),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_head_dat (w_head),
        .o_ent_dat  (w_ent_flat),
        .o_ent_vld  (w_ent_vld)
    );

    // The counter only leaves zero while a load is queued, so reaching the limit implies a non-empty FIFO.
    assign w_starved = (r_starve == SW'(STARVE_LIMIT));
    assign ALU_READY = ~RST & ~w_starved;
    assign w_alu_gnt = ALU_VALID & ALU_READY;
    assign w_ld_gnt  = ~RST & ~w_fifo_empty & (~ALU_VALID | w_starved);

    assign w_gnt_rd  = w_ld_gnt ? w_head.rd  : ALU_RD;
    assign w_gnt_dat = w_ld_gnt ? w_head.dat : ALU_DATA;
    assign w_wr_en   = (w_alu_gnt | w_ld_gnt) & (w_gnt_rd != 5'd31);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_starve <= '0;
        end else if (w_fifo_empty || w_ld_gnt) begin
            r_starve <= '0;
        end else if (w_alu_gnt && !w_starved) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_reg_write <= 1'b0;
            r_wr_reg    <= '0;
            r_wr_data   <= '0;
        end else begin
            r_reg_write <= w_wr_en;
            if (w_wr_en) begin
                r_wr_reg  <= w_gnt_rd;
                r_wr_data <= w_gnt_dat;
            end
        end
    end

    // X31 entries are queued normally but never flagged; the zero register has no hazard.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_ent_vld[i] && (w_ent_flat[i*ENT_W + DATA_W +: 5] != 5'd31)) begin
                w_pending[w_ent_flat[i*ENT_W + DATA_W +: 5]] = 1'b1;
            end
        end
    end

    // Outputs are forced low during reset so a write queued just before reset never reaches the register file.
    assign REG_WRITE = r_reg_write & ~RST;
    assign WR_REG    = RST ? '0 : r_wr_reg;
    assign WR_DATA   = RST ? '0 : r_wr_data;
    assign PENDING   = RST ? '0 : w_pending;
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    logic        CLK = 1'b0;
    logic        RST;
    logic        ALU_VALID;
    logic        ALU_READY;
    logic [4:0]  ALU_RD;
    logic [63:0] ALU_DATA;
    logic        LD_VALID;
    logic        LD_READY;
    logic [4:0]  LD_RD;
    logic [63:0] LD_DATA;
    logic        REG_WRITE;
    logic [4:0]  WR_REG;
    logic [63:0] WR_DATA;
    logic [31:0] PENDING;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] dat;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 CLK = ~CLK;

    wb_arbiter #(
        .DATA_W       (64),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ALU_VALID (ALU_VALID),
        .ALU_READY (ALU_READY),
        .ALU_RD    (ALU_RD),
        .ALU_DATA  (ALU_DATA),
        .LD_VALID  (LD_VALID),
        .LD_READY  (LD_READY),
        .LD_RD     (LD_RD),
        .LD_DATA   (LD_DATA),
        .REG_WRITE (REG_WRITE),
        .WR_REG    (WR_REG),
        .WR_DATA   (WR_DATA),
        .PENDING   (PENDING)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [63:0] dat);
        exp_q.push_back({rd, dat});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: every register-file write must match the oldest expected write.
    always @(negedge CLK) begin
        if (REG_WRITE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", WR_REG, WR_DATA);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_reg", 64'(WR_REG), 64'(e.rd));
                check("wr_data", WR_DATA, e.dat);
            end
        end
    end

    initial begin
        int   k;
        int   ldn;
        logic ea;

        RST = 1'b1; ALU_VALID = 1'b0; ALU_RD = '0; ALU_DATA = '0;
        LD_VALID = 1'b0; LD_RD = '0; LD_DATA = '0;
        repeat (3) tick();
        #1;
        check("rst_alu_ready", 64'(ALU_READY), 64'(0));
        check("rst_ld_ready", 64'(LD_READY), 64'(0));
        check("rst_reg_write", 64'(REG_WRITE), 64'(0));
        check("rst_pending", 64'(PENDING), 64'(0));
        check("rst_wr_reg", 64'(WR_REG), 64'(0));
        check("rst_wr_data", WR_DATA, 64'(0));

        // First cycle after reset, with an ALU result offered.
        tick();
        RST = 1'b0;
        ALU_VALID = 1'b1; ALU_RD = 5'd3; ALU_DATA = 64'h1234;
        #1;
        check("post_rst_reg_write", 64'(REG_WRITE), 64'(0));
        check("post_rst_alu_ready", 64'(ALU_READY), 64'(1));
        check("post_rst_ld_ready", 64'(LD_READY), 64'(1));
        expect_wr(5'd3, 64'h1234);
        tick();
        ALU_VALID = 1'b0;
        #1;
        check("t1_reg_write", 64'(REG_WRITE), 64'(1));
        check("t1_wr_reg", 64'(WR_REG), 64'(3));
        check("t1_ld_ready", 64'(LD_READY), 64'(1));
        check("t1_pending", 64'(PENDING), 64'(0));

        // Single load, ALU idle.
        LD_VALID = 1'b1; LD_RD = 5'd7; LD_DATA = 64'hDEAD_BEEF;
        expect_wr(5'd7, 64'hDEAD_BEEF);
        tick();
        LD_VALID = 1'b0;
        #1;
        check("t2_pending_n1", 64'(PENDING), 64'h80);
        check("t2_reg_write_n1", 64'(REG_WRITE), 64'(0));
        tick();
        #1;
        check("t2_reg_write_n2", 64'(REG_WRITE), 64'(1));
        check("t2_wr_reg_n2", 64'(WR_REG), 64'(7));
        check("t2_pending_n2", 64'(PENDING), 64'(0));
        tick();

        // Two loads behind a continuously valid ALU: starvation limit forces them out.
        k = 0;
        ldn = 0;
        for (int c = 0; c < 12; c++) begin
            ALU_VALID = 1'b1; ALU_RD = 5'd2; ALU_DATA = 64'(32'h100 + k);
            LD_VALID = (c < 2); LD_RD = 5'(20 + c); LD_DATA = 64'(32'h2000 + c);
            #1;
            ea = !(c == 5 || c == 10);
            check("t3_alu_ready", 64'(ALU_READY), 64'(ea));
            if (c == 2) begin
                check("t3_ld_ready_full", 64'(LD_READY), 64'(0));
                check("t3_pending_two", 64'(PENDING), 64'h0030_0000);
            end
            if (c == 6) begin
                check("t3_ld_ready_one", 64'(LD_READY), 64'(1));
                check("t3_pending_one", 64'(PENDING), 64'h0020_0000);
            end
            if (ea) begin
                expect_wr(5'd2, 64'(32'h100 + k));
                k++;
            end else begin
                expect_wr(5'(20 + ldn), 64'(32'h2000 + ldn));
                ldn++;
            end
            tick();
        end
        ALU_VALID = 1'b0; LD_VALID = 1'b0;
        #1;
        check("t3_pending_drained", 64'(PENDING), 64'(0));
        tick();
        tick();

        // Writes to X31 from both sources are swallowed.
        ALU_VALID = 1'b1; ALU_RD = 5'd31; ALU_DATA = 64'h55;
        LD_VALID = 1'b1; LD_RD = 5'd31; LD_DATA = 64'h66;
        #1;
        check("t4_alu_ready", 64'(ALU_READY), 64'(1));
        check("t4_ld_ready", 64'(LD_READY), 64'(1));
        tick();
        ALU_VALID = 1'b0; LD_VALID = 1'b0;
        #1;
        check("t4_pending_x31", 64'(PENDING), 64'(0));
        check("t4_reg_write_alu", 64'(REG_WRITE), 64'(0));
        tick();
        #1;
        check("t4_reg_write_ld", 64'(REG_WRITE), 64'(0));
        check("t4_ld_ready_after", 64'(LD_READY), 64'(1));
        tick();

        // Fill the FIFO, then reset mid-stream.
        ALU_VALID = 1'b1; ALU_RD = 5'd4; ALU_DATA = 64'h44;
        LD_VALID = 1'b1; LD_RD = 5'd5; LD_DATA = 64'h55;
        expect_wr(5'd4, 64'h44);
        tick();
        ALU_DATA = 64'h45; LD_RD = 5'd6; LD_DATA = 64'h66;
        #1;
        check("t5_ld_ready_c1", 64'(LD_READY), 64'(1));
        expect_wr(5'd4, 64'h45);
        tick();
        ALU_DATA = 64'h46; LD_VALID = 1'b0;
        #1;
        check("t5_ld_ready_full", 64'(LD_READY), 64'(0));
        check("t5_pending_full", 64'(PENDING), 64'h60);
        check("t5_reg_write_c2", 64'(REG_WRITE), 64'(1));
        tick();
        RST = 1'b1; ALU_VALID = 1'b0;
        #1;
        check("t5_rst_reg_write", 64'(REG_WRITE), 64'(0));
        check("t5_rst_alu_ready", 64'(ALU_READY), 64'(0));
        check("t5_rst_ld_ready", 64'(LD_READY), 64'(0));
        check("t5_rst_pending", 64'(PENDING), 64'(0));
        tick();
        RST = 1'b0;
        #1;
        check("t5_post_reg_write", 64'(REG_WRITE), 64'(0));
        check("t5_post_pending", 64'(PENDING), 64'(0));
        check("t5_post_ld_ready", 64'(LD_READY), 64'(1));
        check("t5_post_wr_reg", 64'(WR_REG), 64'(0));
        tick();
        #1;
        check("t5_post2_reg_write", 64'(REG_WRITE), 64'(0));
        tick();

        // Streaming loads with simultaneous enqueue and dequeue.
        for (int c = 0; c < 12; c++) begin
            LD_VALID = (c < 10); LD_RD = 5'(c + 1); LD_DATA = 64'(32'h3000 + c + 1);
            #1;
            if (c < 10) begin
                check("t6_ld_ready", 64'(LD_READY), 64'(1));
                expect_wr(5'(c + 1), 64'(32'h3000 + c + 1));
            end
            if (c >= 1 && c <= 10) check("t6_pending", 64'(PENDING), 64'(32'd1 << c));
            if (c == 11) check("t6_pending_empty", 64'(PENDING), 64'(0));
            if (c >= 2) check("t6_reg_write", 64'(REG_WRITE), 64'(1));
            tick();
        end
        LD_VALID = 1'b0;
        #1;
        check("t6_reg_write_end", 64'(REG_WRITE), 64'(0));

        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
